// File: rtl/ram_copy_dma.sv
// Word-RAM initiator: copies len_words words src->dst or fills dst with a constant, one access in flight.
// First mem_req 1 cycle after start; 6 cycles/word copy, 3 cycles/word fill; each access waits at most TIMEOUT cycles.
module ram_copy_dma #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             fill,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  input  logic [31:0]      fill_value,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      err_addr,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_req,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_rvalid,
  input  logic             mem_fault
);

  localparam int               TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    FINISH
  } state_t;

  state_t           state;
  logic [31:0]      cur_src;
  logic [31:0]      cur_dst;
  logic [31:0]      fill_q;
  logic [LEN_W-1:0] remaining;
  logic             fill_mode;
  logic [TMR_W-1:0] timer;
  logic [31:0]      nxt_src;
  logic [31:0]      nxt_dst;

  assign nxt_src = cur_src + 32'd4;
  assign nxt_dst = cur_dst + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_addr   <= '0;
      words_done <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'h0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cur_src    <= '0;
      cur_dst    <= '0;
      fill_q     <= '0;
      remaining  <= '0;
      fill_mode  <= 1'b0;
      timer      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            error      <= 1'b0;
            err_addr   <= '0;
            words_done <= '0;
            cur_src    <= src_addr;
            cur_dst    <= dst_addr;
            remaining  <= len_words;
            fill_mode  <= fill;
            fill_q     <= fill_value;
            // Source alignment only matters when the source is actually read.
            if (!fill && src_addr[1:0] != 2'b00) begin
              error    <= 1'b1;
              err_addr <= src_addr;
              done     <= 1'b1;
              state    <= FINISH;
            end else if (dst_addr[1:0] != 2'b00) begin
              error    <= 1'b1;
              err_addr <= dst_addr;
              done     <= 1'b1;
              state    <= FINISH;
            end else if (len_words == '0) begin
              done  <= 1'b1;
              state <= FINISH;
            end else if (fill) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_be    <= 4'hF;
              mem_addr  <= dst_addr;
              mem_wdata <= fill_value;
              state     <= WR_REQ;
            end else begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_be   <= 4'hF;
              mem_addr <= src_addr;
              state    <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          mem_req <= 1'b0;
          mem_be  <= 4'h0;
          timer   <= '0;
          if (mem_fault) begin
            error    <= 1'b1;
            err_addr <= cur_src;
            done     <= 1'b1;
            state    <= FINISH;
          end else begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // mem_wdata doubles as the read-data holding register for copy mode.
          if (mem_rvalid) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_be    <= 4'hF;
            mem_addr  <= cur_dst;
            mem_wdata <= mem_rdata;
            state     <= WR_REQ;
          end else if (timer == TMR_LAST) begin
            error    <= 1'b1;
            err_addr <= cur_src;
            done     <= 1'b1;
            state    <= FINISH;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WR_REQ: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          mem_be  <= 4'h0;
          timer   <= '0;
          if (mem_fault) begin
            error    <= 1'b1;
            err_addr <= cur_dst;
            done     <= 1'b1;
            state    <= FINISH;
          end else begin
            state <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (mem_rvalid) begin
            words_done <= words_done + 1'b1;
            cur_src    <= nxt_src;
            cur_dst    <= nxt_dst;
            remaining  <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) begin
              done  <= 1'b1;
              state <= FINISH;
            end else if (fill_mode) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_be    <= 4'hF;
              mem_addr  <= nxt_dst;
              mem_wdata <= fill_q;
              state     <= WR_REQ;
            end else begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_be   <= 4'hF;
              mem_addr <= nxt_src;
              state    <= RD_REQ;
            end
          end else if (timer == TMR_LAST) begin
            error    <= 1'b1;
            err_addr <= cur_dst;
            done     <= 1'b1;
            state    <= FINISH;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
